// File: rtl/seg_display_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
package seg_display_scan_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Width of the binary value fed through the double-dabble converter
  localparam int CONV_BITS = 14;

  typedef enum logic [1:0] {
    CONV_LOAD  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_STORE = 2'd2
  } conv_state_e;

  typedef enum logic [1:0] {
    SRC_LEGS = 2'd0,
    SRC_HEAD = 2'd1,
    SRC_RES  = 2'd2
  } src_sel_e;

  // Map one BCD digit to its segment pattern; non-decimal nibbles show a dash
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_display_scan_bin2bcd_seq.sv
// Sequential 14-bit double-dabble converter: LOAD, 14 x SHIFT, STORE.
module bin2bcd_seq
  import seg_display_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  conv_state_e state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [CONV_BITS-1:0] bin_q, bin_d;
  logic [15:0]          bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          adj;

  // Converter state register; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_LOAD;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: snapshot, add-3-then-shift per bit, then hold for one store cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    case (state_q)
      CONV_LOAD: begin
        if (start) begin
          bin_d   = value[CONV_BITS-1:0];
          bcd_d   = '0;
          ovf_d   = (value > 32'd9999);
          cnt_d   = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(CONV_BITS - 1)) begin
          state_d = CONV_STORE;
        end
      end
      CONV_STORE: begin
        state_d = CONV_LOAD;
      end
      default: begin
        state_d = CONV_LOAD;
      end
    endcase
  end

  assign done = (state_q == CONV_STORE);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_display_scan.sv
// 4-digit multiplexed common-anode display driver with edit and result modes.
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] legsin,
  input  logic [31:0] headin,
  input  logic [3:0]  dotpos_pro,
  input  logic        output_display,
  input  logic [31:0] result,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               scan_wrap;

  src_sel_e    src_q, src_d;
  logic [31:0] conv_value;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic        conv_ovf;

  logic [15:0] legs_bcd_q, legs_bcd_d, head_bcd_q, head_bcd_d, res_bcd_q, res_bcd_d;
  logic        legs_ovf_q, legs_ovf_d, head_ovf_q, head_ovf_d, res_ovf_q, res_ovf_d;

  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [15:0] edit_bcd;
  logic        edit_dash;
  logic [3:0]  nib;
  logic        lead_zero;

  // Pick which input feeds the converter on its next LOAD
  always_comb begin
    conv_value = legsin;
    case (src_q)
      SRC_LEGS: conv_value = legsin;
      SRC_HEAD: conv_value = headin;
      SRC_RES:  conv_value = result;
      default:  conv_value = legsin;
    endcase
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (1'b1),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Commit finished conversions to the display shadows and rotate the source
  always_comb begin
    src_d      = src_q;
    legs_bcd_d = legs_bcd_q;
    head_bcd_d = head_bcd_q;
    res_bcd_d  = res_bcd_q;
    legs_ovf_d = legs_ovf_q;
    head_ovf_d = head_ovf_q;
    res_ovf_d  = res_ovf_q;
    if (conv_done) begin
      case (src_q)
        SRC_LEGS: begin
          legs_bcd_d = conv_bcd;
          legs_ovf_d = conv_ovf;
          src_d      = SRC_HEAD;
        end
        SRC_HEAD: begin
          head_bcd_d = conv_bcd;
          head_ovf_d = conv_ovf;
          src_d      = SRC_RES;
        end
        default: begin
          res_bcd_d  = conv_bcd;
          res_ovf_d  = conv_ovf;
          src_d      = SRC_LEGS;
        end
      endcase
    end
  end

  // Scan slot counter, digit rotation 3->0 and blink phase derived from slot wraps
  always_comb begin
    scan_wrap     = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_wrap) begin
      digit_idx_d = digit_idx_q - 2'd1;
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Build anode, segment and dot for the digit currently being scanned
  always_comb begin
    an_d      = ~(4'b0001 << digit_idx_q);
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
    edit_bcd  = digit_idx_q[1] ? legs_bcd_q : head_bcd_q;
    edit_dash = (digit_idx_q[1] ? legs_ovf_q : head_ovf_q) || (edit_bcd[15:8] != 8'd0);
    nib       = res_bcd_q[{digit_idx_q, 2'b00} +: 4];
    lead_zero = 1'b0;
    case (digit_idx_q)
      2'd3:    lead_zero = (res_bcd_q[15:12] == 4'd0);
      2'd2:    lead_zero = (res_bcd_q[15:8] == 8'd0);
      2'd1:    lead_zero = (res_bcd_q[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
    if (output_display) begin
      if (res_ovf_q) begin
        seg_d = SEG_DASH;
      end else if (lead_zero) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg_encode(nib);
      end
    end else begin
      nib   = digit_idx_q[0] ? edit_bcd[7:4] : edit_bcd[3:0];
      seg_d = edit_dash ? SEG_DASH : seg_encode(nib);
      dp_d  = dotpos_pro[digit_idx_q];
      if (!dotpos_pro[digit_idx_q] && !blink_phase_q) begin
        seg_d = SEG_BLANK;
      end
    end
  end

  // All display-side state, shadows and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= 2'd3;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      src_q         <= SRC_LEGS;
      legs_bcd_q    <= '0;
      head_bcd_q    <= '0;
      res_bcd_q     <= '0;
      legs_ovf_q    <= 1'b0;
      head_ovf_q    <= 1'b0;
      res_ovf_q     <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      src_q         <= src_d;
      legs_bcd_q    <= legs_bcd_d;
      head_bcd_q    <= head_bcd_d;
      res_bcd_q     <= res_bcd_d;
      legs_ovf_q    <= legs_ovf_d;
      head_ovf_q    <= head_ovf_d;
      res_ovf_q     <= res_ovf_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan with a short scan period and fast blink.
module tb_seg_display_scan;

  localparam int SD = 4;
  localparam int BT = 2;
  localparam logic [6:0] C_DASH  = 7'b0111111;
  localparam logic [6:0] C_BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] legsin, headin, result;
  logic [3:0]  dotpos_pro;
  logic        output_display;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int unsigned cyc;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] legs;
    logic [31:0] head;
    logic [3:0]  dot;
    logic        mode;
    logic [31:0] res;
    logic [6:0]  s3, s2, s1, s0;
    logic [3:0]  edp;
  } vec_t;

  vec_t tab [13];

  seg_display_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk            (clk),
    .rst            (rst),
    .legsin         (legsin),
    .headin         (headin),
    .dotpos_pro     (dotpos_pro),
    .output_display (output_display),
    .result         (result),
    .an             (an),
    .seg            (seg),
    .dp             (dp)
  );

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Digit shown after edge n is the one selected after edge n-1
  function automatic int idx_at(input int unsigned n);
    int unsigned wraps;
    wraps = (n - 1) / SD;
    return 3 - int'(wraps % 4);
  endfunction

  function automatic logic phase_at(input int unsigned n);
    int unsigned wraps;
    wraps = (n - 1) / SD;
    return ((wraps / BT) % 2) == 0;
  endfunction

  // Reference display contents computed directly from decimal arithmetic
  function automatic logic [11:0] model(input int unsigned n, input int unsigned lv,
                                        input int unsigned hv, input logic [3:0] dot,
                                        input logic mode, input int unsigned rv);
    int          idx;
    int unsigned v, p10;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        ed;
    idx = idx_at(n);
    ea = 4'b1111;
    ea[idx] = 1'b0;
    if (mode) begin
      ed = 1'b1;
      p10 = (idx == 3) ? 1000 : (idx == 2) ? 100 : (idx == 1) ? 10 : 1;
      if (rv > 9999) es = C_DASH;
      else if (idx > 0 && rv < p10) es = C_BLANK;
      else es = code_of(int'((rv / p10) % 10));
    end else begin
      v = (idx >= 2) ? lv : hv;
      ed = dot[idx];
      if (v > 99) es = C_DASH;
      else es = code_of(int'((idx % 2 == 1) ? v / 10 : v % 10));
      if (!dot[idx] && !phase_at(n)) es = C_BLANK;
    end
    return {ea, es, ed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] l, input logic [31:0] h,
                               input logic [3:0] d, input logic m, input logic [31:0] r);
    legsin = l;
    headin = h;
    dotpos_pro = d;
    output_display = m;
    result = r;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ea,
                             input logic [6:0] es, input logic ed);
    n_checks++;
    if ({an, seg, dp} !== {ea, es, ed}) begin
      n_fail++;
      $display("[TB] FAIL %s (cyc %0d): got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, cyc, an, seg, dp, ea, es, ed);
    end
  endtask

  task automatic checkModel(input string name);
    logic [11:0] r;
    r = model(cyc, legsin, headin, dotpos_pro, output_display, result);
    checkOutput(name, r[11:8], r[7:1], r[0]);
  endtask

  initial begin
    int         idx;
    logic [6:0] es;
    logic [6:0] last0;
    logic       seen6;
    logic       aligned;

    tab[0]  = '{32'd47, 32'd5, 4'b0111, 1'b0, 32'd0, 7'b0011001, 7'b1111000, 7'b1000000, 7'b0010010, 4'b0111};
    tab[1]  = '{32'd123, 32'd5, 4'b1111, 1'b0, 32'd0, C_DASH, C_DASH, 7'b1000000, 7'b0010010, 4'b1111};
    tab[2]  = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'd305, C_BLANK, 7'b0110000, 7'b1000000, 7'b0010010, 4'b1111};
    tab[3]  = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'd10000, C_DASH, C_DASH, C_DASH, C_DASH, 4'b1111};
    tab[4]  = '{32'd0, 32'd0, 4'b0000, 1'b1, 32'd0, C_BLANK, C_BLANK, C_BLANK, 7'b1000000, 4'b1111};
    tab[5]  = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'd9999, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 4'b1111};
    tab[6]  = '{32'd99, 32'd100, 4'b1010, 1'b0, 32'd0, 7'b0010000, 7'b0010000, C_DASH, C_DASH, 4'b1010};
    tab[7]  = '{32'd0, 32'd9, 4'b0000, 1'b0, 32'd0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0010000, 4'b0000};
    tab[8]  = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'd7, C_BLANK, C_BLANK, C_BLANK, 7'b1111000, 4'b1111};
    tab[9]  = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'd1000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111};
    tab[10] = '{32'd16384, 32'd42, 4'b1101, 1'b0, 32'd0, C_DASH, C_DASH, 7'b0011001, 7'b0100100, 4'b1101};
    tab[11] = '{32'd0, 32'd0, 4'b1111, 1'b1, 32'hFFFF_FFFF, C_DASH, C_DASH, C_DASH, C_DASH, 4'b1111};
    tab[12] = '{32'd8, 32'd60, 4'b1111, 1'b0, 32'd0, 7'b1000000, 7'b0000000, 7'b0000010, 7'b1000000, 4'b1111};

    // Power-on reset and first slot
    rst = 1'b0;
    applyStimulus(32'd47, 32'd5, 4'b1111, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1 checkOutput("reset_values", 4'b1111, C_BLANK, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("first_slot_zero_shadow", 4'b0111, 7'b1000000, 1'b1);

    // Table-driven vectors, each held long enough for every shadow to refresh
    for (int v = 0; v < 13; v++) begin
      applyStimulus(tab[v].legs, tab[v].head, tab[v].dot, tab[v].mode, tab[v].res);
      repeat (70) tick();
      for (int c = 0; c < 4 * SD; c++) begin
        idx = idx_at(cyc);
        case (idx)
          3: es = tab[v].s3;
          2: es = tab[v].s2;
          1: es = tab[v].s1;
          default: es = tab[v].s0;
        endcase
        if (!tab[v].mode && !tab[v].dot[idx] && !phase_at(cyc)) es = C_BLANK;
        checkOutput($sformatf("table_%0d_digit%0d", v, idx), ~(4'b0001 << idx), es, tab[v].edp[idx]);
        tick();
      end
    end

    // Asynchronous reset in the middle of a run
    applyStimulus(32'd47, 32'd5, 4'b1111, 1'b0, 32'd305);
    repeat (23) tick();
    #3 rst = 1'b1;
    #1 checkOutput("midrun_reset_values", 4'b1111, C_BLANK, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("midrun_reset_first_slot", 4'b0111, 7'b1000000, 1'b1);

    // Randomized settings compared against the arithmetic model
    for (int r = 0; r < 16; r++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 120),
                    $urandom_range(0, 130), 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 12000));
      repeat (70) tick();
      for (int c = 0; c < 4 * SD; c++) begin
        checkModel($sformatf("random_%0d", r));
        tick();
      end
    end

    // Change headin while the HEAD conversion is shifting
    applyStimulus(32'd47, 32'd5, 4'b1111, 1'b0, 32'd0);
    repeat (70) tick();
    aligned = 1'b0;
    for (int i = 0; i < 60 && !aligned; i++) begin
      if (cyc % 48 == 20) aligned = 1'b1;
      else tick();
    end
    n_checks++;
    if (!aligned) begin
      n_fail++;
      $display("[TB] FAIL align_head_shift: got cyc=%0d, want cyc%%48=20", cyc);
    end
    headin = 32'd6;
    last0 = 7'b1111111;
    seen6 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (idx_at(cyc) == 0) begin
        n_checks++;
        if (seg !== 7'b0010010 && seg !== 7'b0000010) begin
          n_fail++;
          $display("[TB] FAIL head_change_intermediate: got seg=%b, want 0010010 or 0000010", seg);
        end
        last0 = seg;
        if (seg === 7'b0000010) seen6 = 1'b1;
      end
    end
    n_checks++;
    if (!seen6 || last0 !== 7'b0000010) begin
      n_fail++;
      $display("[TB] FAIL head_change_final: got seg=%b, want 0000010", last0);
    end
    checkModel("head_change_model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
